if_fetch_buffer: RTL and testbench

- Instruction-fetch stage directly downstream of the program-counter stage.
- Accepts the next PC, issues a word read to instruction memory over a req/ack handshake, and queues the {pc, instruction} pair in a small FIFO.
- Presents queued entries to decode with valid/ready.
- Branch redirect flushes the queue; any in-flight read's data is discarded.

---
 rtl/if_pkg.sv | 26 ++
 rtl/if_sync_fifo.sv | 70 +++++++
 rtl/if_fetch_buffer.sv | 120 ++++++++++++
 tb/tb_if_fetch_buffer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// ============================================================================
// if_pkg : shared types and default sizes for the instruction-fetch buffer
// Revision: 1.0
// ============================================================================
`default_nettype none

package if_pkg;

  localparam int IF_DEPTH  = 4;
  localparam int IF_ADDR_W = 32;
  localparam int IF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fsm_state_t;

  typedef struct packed {
    logic [IF_ADDR_W-1:0] pc;
    logic [IF_DATA_W-1:0] instr;
  } entry_t;

endpackage

`default_nettype wire

// File: rtl/if_sync_fifo.sv
// ============================================================================
// if_sync_fifo : circular in-order FIFO with push/pop/clear, head shown
//                combinationally from storage
// Revision: 1.0
// ============================================================================
`default_nettype none

module if_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop frees the slot in the same cycle, so push at full is legal with it.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/if_fetch_buffer.sv
// ============================================================================
// if_fetch_buffer : fetch stage; issues one imem read per accepted PC and
//                   queues {pc, instr} for decode. Optional: IF_BYPASS_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module if_fetch_buffer
  import if_pkg::*;
#(
  parameter int DEPTH  = IF_DEPTH,
  parameter int ADDR_W = IF_ADDR_W,
  parameter int DATA_W = IF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              pc_valid,
  output logic              pc_ready,
  input  logic              flush,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [DATA_W-1:0] inst_data
);

  fsm_state_t              state;
  logic [ADDR_W-1:0]       pc_q;
  logic [ADDR_W-1:0]       addr_q;
  logic                    req_q;

  logic                    accept;
  logic                    bypass;
  logic                    fifo_push;
  logic                    fifo_pop;
  logic                    fifo_empty;
  logic                    fifo_full;
  logic [ADDR_W+DATA_W-1:0] fifo_rdata;

`ifdef IF_BYPASS_EN
  assign bypass = (state == WAIT) && fifo_empty && imem_ack && !flush;
`else
  assign bypass = 1'b0;
`endif

  assign fifo_pop  = !fifo_empty && inst_ready;
  // A bypassed word that decode takes immediately never needs a slot.
  assign fifo_push = (state == WAIT) && imem_ack && !flush && !(bypass && inst_ready);

  assign pc_ready  = rst && (state == IDLE) && !flush && (!fifo_full || fifo_pop);
  assign accept    = pc_valid && pc_ready;

  assign imem_req  = req_q;
  assign imem_addr = addr_q;

  assign inst_valid = !fifo_empty || bypass;
  assign inst_pc    = bypass ? pc_q       : fifo_rdata[ADDR_W+DATA_W-1:DATA_W];
  assign inst_data  = bypass ? imem_rdata : fifo_rdata[DATA_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      pc_q   <= '0;
      addr_q <= '0;
      req_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            pc_q   <= pc_in;
            addr_q <= {pc_in[ADDR_W-1:2], 2'b00};
            req_q  <= 1'b1;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (imem_ack) begin
            req_q <= 1'b0;
            state <= IDLE;
          end else if (flush) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          // The outstanding read must still complete; its data is dropped.
          if (imem_ack) begin
            req_q <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          req_q <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  if_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_W + DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .clear (flush),
    .wdata ({pc_q, imem_rdata}),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_buffer.sv
// ============================================================================
// tb_if_fetch_buffer : directed + random stimulus against a queue-based model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_if_fetch_buffer;
  import if_pkg::*;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic [31:0] pc_in;
  logic        pc_valid;
  logic        pc_ready;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_pc;
  logic [31:0] inst_data;

  if_fetch_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_in      (pc_in),
    .pc_valid   (pc_valid),
    .pc_ready   (pc_ready),
    .flush      (flush),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst_pc    (inst_pc),
    .inst_data  (inst_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: queue of expected entries plus the one outstanding read.
  entry_t      q[$];
  bit          m_outst;
  bit          m_discard;
  logic [31:0] m_pc;
  int          m_age;
  int          ack_delay;
  bit          rand_delay;
  bit          idle_noise;

  int vectors;
  int miscompares;
  int accepts;
  int pops;
  bit seen_dead;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h11;
      32'h4:   return 32'h22;
      32'h8:   return 32'h33;
      32'h20:  return 32'hDEADBEEF;
      default: return (a * 32'h9E3779B1) + 32'h1234;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    bit     byp;
    bit     exp_valid;
    bit     exp_pop;
    bit     exp_pc_ready;
    entry_t head;
    imem_ack   = m_outst ? (m_age >= ack_delay) : (idle_noise && ($urandom_range(0, 3) == 0));
    imem_rdata = m_outst ? mem_word({m_pc[31:2], 2'b00}) : $urandom;
    byp = 1'b0;
`ifdef IF_BYPASS_EN
    byp = m_outst && !m_discard && imem_ack && !flush && (q.size() == 0);
`endif
    exp_valid = (q.size() > 0) || byp;
    if (q.size() > 0) head = q[0];
    else              head = '{pc: m_pc, instr: imem_rdata};
    exp_pop      = exp_valid && inst_ready;
    exp_pc_ready = !m_outst && !flush && ((q.size() < DEPTH) || exp_pop);
    #1;
    chk("pc_ready", pc_ready, exp_pc_ready);
    chk("imem_req", imem_req, m_outst);
    chk("inst_valid", inst_valid, exp_valid);
    if (exp_valid) begin
      chk("inst_pc", inst_pc, head.pc);
      chk("inst_data", inst_data, head.instr);
    end
    if (m_outst) chk("imem_addr", imem_addr, {m_pc[31:2], 2'b00});
    if (inst_valid && inst_data == 32'hDEADBEEF) seen_dead = 1'b1;
    if (pc_valid && pc_ready) accepts++;
    if (inst_valid && inst_ready) pops++;
    @(posedge clk);
    if (flush) q.delete();
    else if (exp_pop && q.size() > 0) void'(q.pop_front());
    if (m_outst && imem_ack) begin
      if (!m_discard && !flush && !(byp && inst_ready))
        q.push_back('{pc: m_pc, instr: imem_rdata});
      m_outst = 1'b0;
    end else if (m_outst && flush) begin
      m_discard = 1'b1;
    end
    if (pc_valid && exp_pc_ready) begin
      m_outst   = 1'b1;
      m_discard = 1'b0;
      m_pc      = pc_in;
      m_age     = 0;
      if (rand_delay) ack_delay = $urandom_range(0, 3);
    end else if (m_outst) begin
      m_age++;
    end
    @(negedge clk);
  endtask

  task automatic fetch(input logic [31:0] pc, input int dly, input int flush_age);
    int n;
    ack_delay = dly;
    pc_in     = pc;
    pc_valid  = 1'b1;
    n = 0;
    while (!m_outst && n < 50) begin
      cycle();
      n++;
    end
    pc_valid = 1'b0;
    while (m_outst && n < 50) begin
      flush = (flush_age >= 0) && (m_age == flush_age) && !m_discard;
      cycle();
      flush = 1'b0;
      n++;
    end
    chk("fetch_bound", (n < 50), 1'b1);
  endtask

  task automatic model_reset();
    q.delete();
    m_outst   = 1'b0;
    m_discard = 1'b0;
    m_pc      = '0;
    m_age     = 0;
  endtask

  initial begin
    int a0;
    vectors = 0; miscompares = 0; accepts = 0; pops = 0; seen_dead = 1'b0;
    rand_delay = 1'b0; idle_noise = 1'b0; ack_delay = 0;
    rst = 1'b0; pc_in = '0; pc_valid = 1'b0; flush = 1'b0;
    imem_ack = 1'b0; imem_rdata = '0; inst_ready = 1'b0;
    model_reset();

    // Reset state
    @(negedge clk);
    #1;
    chk("rst_pc_ready", pc_ready, 1'b0);
    chk("rst_imem_req", imem_req, 1'b0);
    chk("rst_inst_valid", inst_valid, 1'b0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_inst_data", inst_data, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // In-order fetch of 0x0/0x4/0x8 with immediate acks
    inst_ready = 1'b1;
    fetch(32'h0, 0, -1);
    fetch(32'h4, 0, -1);
    fetch(32'h8, 0, -1);
    repeat (3) cycle();

    // Backpressure: only DEPTH fetches fit
    inst_ready = 1'b0;
    pc_in = 32'h100; pc_valid = 1'b1; ack_delay = 0;
    a0 = accepts;
    for (int i = 0; i < 14; i++) begin
      cycle();
      if (accepts != a0 + 0) pc_in = 32'h100 + 32'((accepts - a0) * 4);
    end
    chk("full_accepts", accepts - a0, 4);
    inst_ready = 1'b1;
    cycle();
    inst_ready = 1'b0;
    cycle();
    chk("after_pop_accepts", accepts - a0, 5);
    pc_valid = 1'b0;
    inst_ready = 1'b1;
    repeat (8) cycle();

    // Flush while waiting: poisoned word must never reach decode
    seen_dead = 1'b0;
    fetch(32'h20, 3, 0);
    repeat (2) cycle();
    chk("deadbeef_seen", seen_dead, 1'b0);
    fetch(32'h40, 1, -1);
    repeat (2) cycle();

    // Flush in the same cycle as the ack
    fetch(32'h10, 0, 0);
    cycle();
    chk("flush_ack_valid", inst_valid, 1'b0);

    // Three queued, then ack and pop together
    inst_ready = 1'b0;
    fetch(32'h200, 0, -1);
    fetch(32'h204, 0, -1);
    fetch(32'h208, 0, -1);
    pc_in = 32'h20C; pc_valid = 1'b1; ack_delay = 0;
    cycle();
    pc_valid = 1'b0;
    inst_ready = 1'b1;
    cycle();
    inst_ready = 1'b0;
    cycle();
    a0 = pops;
    inst_ready = 1'b1;
    repeat (6) cycle();
    chk("drain_pops", pops - a0, 3);

    // Reset mid-WAIT with an entry queued
    inst_ready = 1'b0;
    fetch(32'h2F0, 0, -1);
    pc_in = 32'h300; pc_valid = 1'b1; ack_delay = 5;
    cycle();
    pc_valid = 1'b0;
    cycle();
    rst = 1'b0;
    #1;
    chk("midrst_imem_req", imem_req, 1'b0);
    chk("midrst_inst_valid", inst_valid, 1'b0);
    chk("midrst_pc_ready", pc_ready, 1'b0);
    chk("midrst_inst_pc", inst_pc, 32'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    inst_ready = 1'b1;
    fetch(32'h400, 0, -1);
    repeat (2) cycle();

    // Random traffic
    rand_delay = 1'b1;
    idle_noise = 1'b1;
    for (int i = 0; i < 400; i++) begin
      pc_valid   = ($urandom_range(0, 9) < 7);
      pc_in      = $urandom;
      inst_ready = ($urandom_range(0, 9) < 6);
      flush      = ($urandom_range(0, 19) == 0);
      cycle();
    end
    flush = 1'b0; pc_valid = 1'b0; inst_ready = 1'b1; idle_noise = 1'b0;
    repeat (8) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
